// File: rtl/dmem_responder_pkg.sv
// Shared CPU parameters, extended with the data-memory responder's types.
// Provides xlen, the default array depth, the responder state encoding and a
// helper that extracts the 16-bit read window from a 32-bit word.
package cpu_parameters;

  localparam int xlen             = 32;
  localparam int DMEM_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Shift the word right by whole bytes and keep the low half; bytes shifted
  // in from above the word are zero.
  function automatic logic [15:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return shifted[15:0];
  endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Synchronous single-port word array with per-byte write enables.
// A read returns data on the clock after the enabled edge; the read register
// holds its value while the port is idle.
module dmem_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write or registered read on an enabled edge.
  // NOTE: the array has no reset; clearing it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: samples one read/write request in IDLE, commits
// writes at the sampling edge and answers with a one-cycle hit pulse.
// Optional feature: define DMEM_WAIT_EN to insert WAIT_CYCLES wait cycles
// (WAIT state plus a 4-bit down-counter) before the response.
module dmem_responder
  import cpu_parameters::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [xlen-1:0] req_adr,
  input  logic [xlen-1:0] req_data,
  input  logic [3:0]      req_strobe,
  output logic            hit,
  output logic [15:0]     mem_res,
  output logic            busy,
  output logic            err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must lie in 1..15");
  end

  dmem_state_t state, state_nxt;

  logic        take;
  logic        in_range;
  logic        is_read_q;
  logic        oor_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata;

  // Any upper address bit set, or an index past the array end, is out of range.
  assign in_range = (req_adr >> 2) < xlen'(DEPTH_WORDS);
  assign take     = (state == IDLE) && (r_v || w_v);

  // A simultaneous read and write is treated as a write.
  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .en    (take && in_range && rst_n),
    .we    (w_v),
    .be    (req_strobe),
    .addr  (req_adr[AW+1:2]),
    .wdata (req_data[31:0]),
    .rdata (rdata)
  );

`ifdef DMEM_WAIT_EN
  logic [3:0] cnt, cnt_nxt;
`endif

  // State register, wait counter and the request attributes needed at RESP.
  // NOTE: synchronous reset, so rst_n is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_read_q <= 1'b0;
      oor_q     <= 1'b0;
      lane_q    <= 2'b00;
`ifdef DMEM_WAIT_EN
      cnt       <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
`ifdef DMEM_WAIT_EN
      cnt   <= cnt_nxt;
`endif
      if (take) begin
        is_read_q <= !w_v;
        oor_q     <= !in_range;
        lane_q    <= req_adr[1:0];
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  // NOTE: defaults first so every path assigns every signal and no latch forms.
  always_comb begin
    state_nxt = state;
`ifdef DMEM_WAIT_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: begin
        if (take) begin
`ifdef DMEM_WAIT_EN
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES - 1);
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses are decoded from the state so they are zero in every non-RESP cycle.
  assign busy    = (state != IDLE);
  assign hit     = (state == RESP);
  assign err     = hit && oor_q;
  assign mem_res = (hit && is_read_q && !oor_q) ? lane_select(rdata, lane_q) : 16'h0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes the expected
// response (cycle, err, data) from a byte-array model; a monitor compares
// every hit pulse. Works with or without DMEM_WAIT_EN defined.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 3;
`ifdef DMEM_WAIT_EN
  localparam int LAT = 1 + WAITC;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_v, w_v;
  logic [31:0] req_adr, req_data;
  logic [3:0]  req_strobe;
  logic        hit, busy, err;
  logic [15:0] mem_res;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [7:0] mem_m [DEPTH*4];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_v        (r_v),
    .w_v        (w_v),
    .req_adr    (req_adr),
    .req_data   (req_data),
    .req_strobe (req_strobe),
    .hit        (hit),
    .mem_res    (mem_res),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // ---------------- reference model: a plain byte array ----------------
  function automatic bit in_rng(input logic [31:0] adr);
    return (adr >> 2) < DEPTH;
  endfunction

  function automatic logic [15:0] model_read(input logic [31:0] adr);
    int base, lane;
    logic [7:0] lo, hi;
    if (!in_rng(adr)) return 16'h0000;
    base = int'(adr >> 2) * 4;
    lane = int'(adr[1:0]);
    lo   = mem_m[base + lane];
    hi   = (lane == 3) ? 8'h00 : mem_m[base + lane + 1];
    return {hi, lo};
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] strb);
    int base;
    if (!in_rng(adr)) return;
    base = int'(adr >> 2) * 4;
    for (int i = 0; i < 4; i++)
      if (strb[i]) mem_m[base + i] = data[8*i +: 8];
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (hit) begin
      if (sb.size() == 0) flag("unexpected_hit");
      else begin
        e = sb.pop_front();
        check("hit_cycle", cyc, e.cyc);
        check("err", {31'b0, err}, {31'b0, e.err});
        check("mem_res", {16'b0, mem_res}, {16'b0, e.res});
      end
    end else begin
      if (err) flag("err_without_hit");
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        flag("missing_hit");
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit rv, input bit wv, input logic [31:0] adr,
                       input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int n;
    @(negedge clk);
    r_v = rv; w_v = wv; req_adr = adr; req_data = data; req_strobe = strb;
    e.cyc = cyc + LAT;
    e.err = !in_rng(adr);
    e.res = wv ? 16'h0000 : model_read(adr);
    if (wv) model_write(adr, data, strb);
    sb.push_back(e);
    @(negedge clk);
    r_v = 1'b0; w_v = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, LAT);
  endtask

  initial begin
    exp_t e;
    int   c0, n, k;
    logic [31:0] adr;

    rst_n = 1'b0; r_v = 1'b0; w_v = 1'b0;
    req_adr = '0; req_data = '0; req_strobe = '0;
    repeat (3) @(negedge clk);
    check("rst_hit", {31'b0, hit}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_res", {16'b0, mem_res}, 32'd0);
    rst_n = 1'b1;

    // Give the low 64 words known contents.
    for (int i = 0; i < 64; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full-word write then read; byte write into lane 3 then reads.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b0, 1'b1, 32'h13, 32'hAB000000, 4'b1000);
    issue(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h12, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h11, 32'h0, 4'h0);
    // Zero strobe: write dropped, hit still pulses.
    issue(1'b0, 1'b1, 32'h10, 32'h55555555, 4'b0000);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    // Simultaneous read and write acts as a write.
    issue(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b1111);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    // Out of range: read returns 0 with err, write leaves word 0 unchanged.
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    issue(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h8000_0003, 32'h0, 4'h0);

    // Request held high: re-sampled in the IDLE cycle after RESP, not queued.
    @(negedge clk);
    r_v = 1'b1; w_v = 1'b0; req_adr = 32'h12;
    c0 = cyc;
    e.err = 1'b0; e.res = model_read(32'h12);
    e.cyc = c0 + LAT;         sb.push_back(e);
    e.cyc = c0 + 2 * LAT + 1; sb.push_back(e);
    repeat (LAT + 2) @(negedge clk);
    r_v = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end

    // Reset aborts a pending read; written data survives.
    @(negedge clk);
`ifdef DMEM_WAIT_EN
    r_v = 1'b1; req_adr = 32'h20;
    @(negedge clk);
    r_v = 1'b0; rst_n = 1'b0;
    @(negedge clk);
`else
    r_v = 1'b1; req_adr = 32'h20; rst_n = 1'b0;
    @(negedge clk);
    r_v = 1'b0;
`endif
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hit", {31'b0, hit}, 32'd0);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      k   = int'($urandom_range(0, 99));
      adr = (k < 10) ? (32'h1000 | $urandom) : 32'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       issue(1'b1, 1'b0, adr, $urandom, 4'($urandom_range(0, 15)));
        1:       issue(1'b0, 1'b1, adr, $urandom, 4'($urandom_range(0, 15)));
        default: issue(1'b1, 1'b1, adr, $urandom, 4'($urandom_range(0, 15)));
      endcase
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
